// File: rtl/shift_pipe_scheduler.sv
// Round-robin owner of one serial shift chain shared by NUM_REQ requesters.
// Every beat travels with its valid flag and owner tag so the far end can demux it.
module shift_pipe_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int DEPTH     = 2,
  parameter int MAX_BURST = 8,
  parameter int IDW       = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] bit_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               bit_o,
  output logic               valid_o,
  output logic [IDW-1:0]     id_o,
  output logic               busy_o
);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                    state, state_n;
  logic [IDW-1:0]            owner, owner_n, ptr, ptr_n, nxt_ptr;
  logic [CW-1:0]             cnt, cnt_n, cnt_inc;
  logic [NUM_REQ-1:0]        gnt_n;
  logic                      acc, release_c, rotate_c;
  logic [IDW:0]              pick_idle, pick_rearb;
  logic [DEPTH-1:0]          vld_pipe, dat_pipe;
  logic [DEPTH-1:0][IDW-1:0] tag_pipe;

  // Returns {found, index}: first requester at or after start, wrapping, optionally skipping excl.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                           input logic [IDW-1:0]     start,
                                           input logic               excl_en,
                                           input logic [IDW-1:0]     excl);
    logic           found;
    logic [IDW-1:0] idx;
    int             j;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(start) + i) % NUM_REQ;
      if (!found && req[j] && !(excl_en && (j == int'(excl)))) begin
        found = 1'b1;
        idx   = IDW'(j);
      end
    end
    return {found, idx};
  endfunction

  assign acc        = (state == GRANT) && req_i[owner];
  assign nxt_ptr    = (owner == IDW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign cnt_inc    = cnt + CW'(acc);
  assign release_c  = !req_i[owner];
  assign rotate_c   = acc && (cnt_inc == CW'(MAX_BURST));
  assign pick_idle  = rr_pick(req_i, ptr, 1'b0, '0);
  assign pick_rearb = rr_pick(req_i, nxt_ptr, 1'b1, owner);

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (|req_i) begin
          state_n = GRANT;
          owner_n = pick_idle[IDW-1:0];
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (release_c || rotate_c) begin
          ptr_n = nxt_ptr;
          cnt_n = '0;
          if (pick_rearb[IDW]) owner_n = pick_rearb[IDW-1:0];
          else if (!req_i[owner]) state_n = IDLE;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: state_n = IDLE;
    endcase
    gnt_n = (state_n == GRANT) ? (NUM_REQ'(1) << owner_n) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= '0;
      cnt      <= '0;
      gnt_o    <= '0;
      vld_pipe <= '0;
      dat_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      gnt_o <= gnt_n;
      for (int i = DEPTH - 1; i > 0; i--) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
      // Empty cycles inject an all-zero bubble so stale data never reaches the output.
      vld_pipe[0] <= acc;
      dat_pipe[0] <= acc & bit_i[owner];
      tag_pipe[0] <= acc ? owner : '0;
    end
  end

  assign bit_o   = dat_pipe[DEPTH-1];
  assign valid_o = vld_pipe[DEPTH-1];
  assign id_o    = tag_pipe[DEPTH-1];
  assign busy_o  = (state == GRANT) | (|vld_pipe);

endmodule
